zero_cross_detector: RTL and testbench



---
 rtl/zc_pkg.sv | 14 +
 rtl/zc_hold_counter.sv | 39 +++
 rtl/zero_cross_detector.sv | 150 +++++++++++++++
 tb/tb_zero_cross_detector.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zc_pkg.sv
// Shared state encoding and default widths/amplitude for the zero-crossing detector.
package zc_pkg;

  typedef enum logic [1:0] {
    ZC_UNKNOWN = 2'd0,
    ZC_LOW     = 2'd1,
    ZC_HIGH    = 2'd2
  } zc_state_t;

  localparam int ZC_DATA_W = 16;
  localparam int ZC_HOLD_W = 8;
  localparam logic signed [ZC_DATA_W-1:0] ZC_OUT_AMP = 16'sh3FFF;

endpackage

// File: rtl/zc_hold_counter.sv
// Saturating persistence counter; o_reached means "one more qualifying sample meets max(hold_n,1)".
module zc_hold_counter
  import zc_pkg::*;
#(
  parameter int HOLD_W = ZC_HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic [HOLD_W-1:0] i_hold_n,
  output logic              o_reached
);

  logic [HOLD_W-1:0] r_count;
  logic [HOLD_W-1:0] w_count_inc;
  logic [HOLD_W-1:0] w_target;

  // A hold_n that was lowered below the running count still switches on the next qualifying sample.
  always_comb begin
    w_count_inc = (r_count == '1) ? r_count : r_count + HOLD_W'(1);
    w_target    = (i_hold_n == '0) ? HOLD_W'(1) : i_hold_n;
    o_reached   = (w_count_inc >= w_target);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      if (i_clr) begin
        r_count <= '0;
      end else if (i_inc) begin
        r_count <= w_count_inc;
      end
    end
  end

endmodule

// File: rtl/zero_cross_detector.sv
// Hysteresis comparator with persistence filter producing a square-wave stream, rise strobe and edge count.
// Optional ZC_TIMESTAMP_EN adds last_rise_ts, the valid-sample count latched on each rising edge.
module zero_cross_detector
  import zc_pkg::*;
#(
  parameter int                        DATA_W  = ZC_DATA_W,
  parameter int                        HOLD_W  = ZC_HOLD_W,
  parameter logic signed [DATA_W-1:0]  OUT_AMP = DATA_W'(ZC_OUT_AMP)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] S_AXIS_IN_tdata,
  input  logic                     S_AXIS_IN_tvalid,
  input  logic signed [DATA_W-1:0] thr_hi,
  input  logic signed [DATA_W-1:0] thr_lo,
  input  logic [HOLD_W-1:0]        hold_n,
  output logic signed [DATA_W-1:0] M_AXIS_OUT_tdata,
  output logic                     M_AXIS_OUT_tvalid,
  output logic                     rise_pulse,
  output logic [31:0]              edge_count
`ifdef ZC_TIMESTAMP_EN
  ,
  output logic [31:0]              last_rise_ts
`endif
);

  localparam logic signed [DATA_W-1:0] NEG_AMP = -OUT_AMP;

  zc_state_t r_state;
  zc_state_t w_state_next;

  logic                     w_rise_cond;
  logic                     w_fall_cond;
  logic                     w_hold_inc;
  logic                     w_hold_clr;
  logic                     w_hold_reached;
  logic                     w_switch;
  logic                     w_rise_evt;
  logic signed [DATA_W-1:0] r_tdata;
  logic                     r_tvalid;
  logic                     r_rise;
  logic [31:0]              r_edge_count;

  assign w_rise_cond = (S_AXIS_IN_tdata >= thr_hi);
  assign w_fall_cond = (S_AXIS_IN_tdata <= thr_lo);
  assign w_hold_inc  = S_AXIS_IN_tvalid &&
                       (((r_state == ZC_LOW) && w_rise_cond) ||
                        ((r_state == ZC_HIGH) && w_fall_cond));
  assign w_switch    = w_hold_inc && w_hold_reached;

  zc_hold_counter #(
    .HOLD_W(HOLD_W)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .i_en     (S_AXIS_IN_tvalid),
    .i_clr    (w_hold_clr),
    .i_inc    (w_hold_inc),
    .i_hold_n (hold_n),
    .o_reached(w_hold_reached)
  );

  // UNKNOWN resolves immediately (rise wins a tie); LOW/HIGH need the persistence count.
  always_comb begin
    w_state_next = r_state;
    w_hold_clr   = 1'b0;
    w_rise_evt   = 1'b0;
    if (S_AXIS_IN_tvalid) begin
      case (r_state)
        ZC_LOW: begin
          w_hold_clr = !w_rise_cond || w_switch;
          if (w_switch) begin
            w_state_next = ZC_HIGH;
            w_rise_evt   = 1'b1;
          end
        end
        ZC_HIGH: begin
          w_hold_clr = !w_fall_cond || w_switch;
          if (w_switch) begin
            w_state_next = ZC_LOW;
          end
        end
        default: begin
          w_hold_clr = 1'b1;
          if (w_rise_cond) begin
            w_state_next = ZC_HIGH;
          end else if (w_fall_cond) begin
            w_state_next = ZC_LOW;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ZC_UNKNOWN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_rise       <= 1'b0;
      r_edge_count <= '0;
    end else begin
      r_tvalid <= S_AXIS_IN_tvalid;
      r_rise   <= w_rise_evt;
      if (w_rise_evt) begin
        r_edge_count <= r_edge_count + 32'd1;
      end
      case (w_state_next)
        ZC_HIGH: r_tdata <= OUT_AMP;
        ZC_LOW:  r_tdata <= NEG_AMP;
        default: r_tdata <= '0;
      endcase
    end
  end

  assign M_AXIS_OUT_tdata  = r_tdata;
  assign M_AXIS_OUT_tvalid = r_tvalid;
  assign rise_pulse        = r_rise;
  assign edge_count        = r_edge_count;

`ifdef ZC_TIMESTAMP_EN
  logic [31:0] r_sample_cnt;
  logic [31:0] r_last_rise_ts;

  // Latches the index of the sample that completed the rise (count of earlier valid samples).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample_cnt   <= '0;
      r_last_rise_ts <= '0;
    end else begin
      if (S_AXIS_IN_tvalid) begin
        r_sample_cnt <= r_sample_cnt + 32'd1;
      end
      if (w_rise_evt) begin
        r_last_rise_ts <= r_sample_cnt;
      end
    end
  end

  assign last_rise_ts = r_last_rise_ts;
`endif

endmodule

// File: tb/tb_zero_cross_detector.sv
// Self-checking bench for zero_cross_detector: vector table, behavioural model and expected-output queue.
module tb_zero_cross_detector;

  localparam int AMP = 16383;

  typedef struct {
    bit valid;
    int data;
    bit rise;
    bit [31:0] count;
  } exp_t;

  typedef struct {
    bit doRst;
    bit v;
    int d;
    int hi;
    int lo;
    int hold;
    bit ev;
    int ed;
    bit er;
    int ec;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] inData;
  logic               inValid;
  logic signed [15:0] thrHi;
  logic signed [15:0] thrLo;
  logic [7:0]         holdN;
  logic signed [15:0] outData;
  logic               outValid;
  logic               risePulse;
  logic [31:0]        edgeCount;

  exp_t      expQ[$];
  int        testsRun = 0;
  int        testsFailed = 0;
  string     curTag = "init";
  int        mState;
  int        mCnt;
  bit [31:0] mEdge;
  int        sineHalf[16] = '{0, 160, 310, 450, 570, 670, 730, 770, 770, 730, 670, 570, 450, 310, 160, 0};
  vec_t      vecs[18];

  always #5 clk = ~clk;

  zero_cross_detector dut (
    .clk              (clk),
    .rst              (rst),
    .S_AXIS_IN_tdata  (inData),
    .S_AXIS_IN_tvalid (inValid),
    .thr_hi           (thrHi),
    .thr_lo           (thrLo),
    .hold_n           (holdN),
    .M_AXIS_OUT_tdata (outData),
    .M_AXIS_OUT_tvalid(outValid),
    .rise_pulse       (risePulse),
    .edge_count       (edgeCount)
  );

  function automatic int sineAt(int n);
    int k;
    k = n % 30;
    return (k < 15) ? sineHalf[k] : -sineHalf[k - 15];
  endfunction

  task automatic check(string name, logic signed [63:0] act, logic signed [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural reference written from the state descriptions, not the RTL structure.
  task automatic modelStep(input bit v, input int d, input int hi, input int lo, input int hold,
                           output exp_t e);
    int target;
    bit rose;
    target = (hold == 0) ? 1 : hold;
    rose   = 1'b0;
    if (v) begin
      if (mState == 0) begin
        if (d >= hi) mState = 2;
        else if (d <= lo) mState = 1;
        mCnt = 0;
      end else if (mState == 1) begin
        if (d >= hi) begin
          mCnt++;
          if (mCnt >= target) begin
            mState = 2;
            mCnt   = 0;
            rose   = 1'b1;
            mEdge  = mEdge + 32'd1;
          end
        end else begin
          mCnt = 0;
        end
      end else begin
        if (d <= lo) begin
          mCnt++;
          if (mCnt >= target) begin
            mState = 1;
            mCnt   = 0;
          end
        end else begin
          mCnt = 0;
        end
      end
    end
    e.valid = v;
    e.data  = (mState == 2) ? AMP : (mState == 1) ? -AMP : 0;
    e.rise  = rose;
    e.count = mEdge;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s/scoreboard: got empty queue, expected an entry", curTag);
      return;
    end
    e = expQ.pop_front();
    check({curTag, "/tvalid"}, outValid, e.valid);
    check({curTag, "/tdata"}, outData, e.data);
    check({curTag, "/rise_pulse"}, risePulse, e.rise);
    check({curTag, "/edge_count"}, edgeCount, e.count);
  endtask

  task automatic applyStimulus(input bit v, input int d, input int hi, input int lo, input int hold,
                               input exp_t e);
    @(negedge clk);
    inValid = v;
    inData  = 16'(d);
    thrHi   = 16'(hi);
    thrLo   = 16'(lo);
    holdN   = 8'(hold);
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runModel(input bit v, input int d, input int hi, input int lo, input int hold);
    exp_t e;
    modelStep(v, d, hi, lo, hold, e);
    applyStimulus(v, d, hi, lo, hold, e);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst     = 1'b1;
    inValid = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    mState = 0;
    mCnt   = 0;
    mEdge  = '0;
    expQ.delete();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    exp_t e;

    rst     = 1'b1;
    inValid = 1'b0;
    inData  = '0;
    thrHi   = 16'sd100;
    thrLo   = -16'sd100;
    holdN   = 8'd1;

    // Short sequences with hand-derived expectations; doRst restarts from UNKNOWN.
    vecs[0]  = '{1, 1, 50,     100, -100, 2,   1, 0,    0, 0};
    vecs[1]  = '{0, 1, -100,   100, -100, 2,   1, -AMP, 0, 0};
    vecs[2]  = '{0, 1, 100,    100, -100, 2,   1, -AMP, 0, 0};
    vecs[3]  = '{0, 1, 99,     100, -100, 2,   1, -AMP, 0, 0};
    vecs[4]  = '{0, 0, 500,    100, -100, 2,   0, -AMP, 0, 0};
    vecs[5]  = '{0, 1, 100,    100, -100, 2,   1, -AMP, 0, 0};
    vecs[6]  = '{0, 0, -999,   100, -100, 2,   0, -AMP, 0, 0};
    vecs[7]  = '{0, 1, 101,    100, -100, 2,   1, AMP,  1, 1};
    vecs[8]  = '{0, 1, -101,   100, -100, 5,   1, AMP,  0, 1};
    vecs[9]  = '{0, 1, -101,   100, -100, 5,   1, AMP,  0, 1};
    vecs[10] = '{0, 1, -101,   100, -100, 2,   1, -AMP, 0, 1};
    vecs[11] = '{0, 1, 32767,  100, -100, 0,   1, AMP,  1, 2};
    vecs[12] = '{0, 1, -32768, 100, -100, 0,   1, -AMP, 0, 2};
    vecs[13] = '{0, 1, 0,      100, -100, 0,   1, -AMP, 0, 2};
    vecs[14] = '{1, 1, 150,    100, 200,  200, 1, AMP,  0, 0};
    vecs[15] = '{0, 1, 150,    100, 200,  200, 1, AMP,  0, 0};
    vecs[16] = '{0, 1, 150,    100, 200,  200, 1, AMP,  0, 0};
    vecs[17] = '{0, 1, 150,    100, 200,  200, 1, AMP,  0, 0};

    curTag = "reset";
    @(negedge clk);
    @(negedge clk);
    check("reset/tvalid", outValid, 0);
    check("reset/tdata", outData, 0);
    check("reset/rise_pulse", risePulse, 0);
    check("reset/edge_count", edgeCount, 0);
    rst    = 1'b0;
    mState = 0;
    mCnt   = 0;
    mEdge  = '0;

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].doRst) doReset();
      curTag = $sformatf("vec%0d", i);
      e.valid = vecs[i].ev;
      e.data  = vecs[i].ed;
      e.rise  = vecs[i].er;
      e.count = 32'(vecs[i].ec);
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].hi, vecs[i].lo, vecs[i].hold, e);
    end

    doReset();
    curTag = "sine";
    pulses = 0;
    for (int n = 0; n < 100; n++) begin
      runModel(1, sineAt(n), 100, -100, 1);
      if (risePulse === 1'b1) pulses++;
    end
    check("sine/pulse_total", pulses, 3);
    check("sine/final_edge_count", edgeCount, 3);

    doReset();
    curTag = "spike";
    for (int n = 0; n < 60; n++) begin
      runModel(1, (n == 38) ? -500 : sineAt(n), 100, -100, 3);
      if (n == 38) check("spike/held_high", outData, AMP);
    end

    doReset();
    curTag = "toggle";
    for (int n = 0; n < 60; n++) begin
      runModel(1, sineAt(n), 100, -100, 1);
      runModel(0, -1000, 100, -100, 1);
    end
    check("toggle/final_edge_count", edgeCount, 1);

    doReset();
    curTag = "wrap";
    runModel(1, -200, 100, -100, 1);
    @(negedge clk);
    force dut.r_edge_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_edge_count;
    mEdge = 32'hFFFF_FFFF;
    check("wrap/preload", edgeCount, 64'h0000_0000_FFFF_FFFF);
    runModel(1, 200, 100, -100, 1);

    doReset();
    curTag = "midhold";
    runModel(1, -200, 100, -100, 3);
    runModel(1, 150, 100, -100, 3);
    runModel(1, 150, 100, -100, 3);
    @(negedge clk);
    rst     = 1'b1;
    inValid = 1'b0;
    #1;
    check("midhold/async_tvalid", outValid, 0);
    check("midhold/async_tdata", outData, 0);
    check("midhold/async_rise", risePulse, 0);
    check("midhold/async_edge_count", edgeCount, 0);
    @(negedge clk);
    rst    = 1'b0;
    mState = 0;
    mCnt   = 0;
    mEdge  = '0;
    expQ.delete();
    runModel(1, 150, 100, -100, 3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
